// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Handles load-use stalls, ID-resolved branch flushes, and front-end freeze
// during multi-cycle EX ops with a timeout watchdog.
// Optional build macro HAZARD_STALL_CNT_EN enables the saturating stall counter.
module hazard_stall_ctrl #(
   parameter int unsigned MC_MAX_CYCLES = 64,
   parameter int unsigned MC_CNT_W      = 7,
   parameter int unsigned STALL_CNT_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4:0]             ifid_rs,
   input  logic [4:0]             ifid_rt,
   input  logic                   ifid_uses_rt,
   input  logic                   idex_memread,
   input  logic [4:0]             idex_rt,
   input  logic                   branch_taken,
   input  logic                   mc_start,
   input  logic                   mc_done,
   output logic                   pc_ld,
   output logic                   ifid_ld,
   output logic                   ifid_flush,
   output logic                   idex_bubble,
   output logic                   mc_timeout,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MC_WAIT = 1'b1;

   localparam logic [MC_CNT_W-1:0] CNT_LAST = MC_CNT_W'(MC_MAX_CYCLES - 1);

   logic [0:0]          state_q, state_d;
   logic [MC_CNT_W-1:0] cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
   logic                lu_hazard;

   // Load-use hazard: load in ID/EX writes a register the IF/ID op reads.
   assign lu_hazard = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

   // Next-state and zero-latency pipeline control outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timeout_d   = timeout_q;
      pc_ld       = 1'b0;
      ifid_ld     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!rst) begin
         case (state_q)
            RUN: begin
               if (lu_hazard) begin
                  idex_bubble = 1'b1;
               end else if (branch_taken) begin
                  pc_ld      = 1'b1;
                  ifid_ld    = 1'b1;
                  ifid_flush = 1'b1;
               end else if (mc_start) begin
                  // Multi-cycle op issues into ID/EX; front end holds.
                  state_d = MC_WAIT;
                  cnt_d   = '0;
               end else begin
                  pc_ld   = 1'b1;
                  ifid_ld = 1'b1;
               end
            end
            MC_WAIT: begin
               if (mc_done) begin
                  pc_ld   = 1'b1;
                  ifid_ld = 1'b1;
                  state_d = RUN;
               end else begin
                  idex_bubble = 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     timeout_d = 1'b1;
                     state_d   = RUN;
                  end else begin
                     cnt_d = cnt_q + MC_CNT_W'(1);
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // FSM, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign mc_timeout = timeout_q;

`ifdef HAZARD_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where IF/ID is held (flushes load, so not counted).
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!ifid_ld && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives PC write enable, IF/ID load and flush, and the ID/EX bubble (control-zero) select.
- Detects load-use hazards and taken branches/jumps resolved in ID.
- Freezes the front end while a multi-cycle EX unit (mult/div) is busy, with a timeout watchdog.

Parameters:
MC_MAX_CYCLES, 64, max cycles in MC_WAIT before timeout abort (>=2)
MC_CNT_W, 7, width of multi-cycle wait counter (must hold MC_MAX_CYCLES)
STALL_CNT_W, 32, width of optional stall performance counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
ifid_rs  input  5  rs field of instruction in IF/ID
ifid_rt  input  5  rt field of instruction in IF/ID
ifid_uses_rt  input  1  IF/ID instruction reads rt as a source
idex_memread  input  1  instruction in ID/EX is a load
idex_rt  input  5  destination register of load in ID/EX
branch_taken  input  1  ID-stage branch comparator says taken, or jump decoded
mc_start  input  1  IF/ID instruction is a multi-cycle op issuing this cycle
mc_done  input  1  multi-cycle unit result ready (1-cycle pulse)
pc_ld  output  1  PC register load enable
ifid_ld  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID flush; overrides ifid_ld in the register
idex_bubble  output  1  zero control bits into ID/EX
mc_timeout  output  1  sticky flag, multi-cycle op exceeded MC_MAX_CYCLES
stall_count  output  STALL_CNT_W  cycles with ifid_ld=0 (optional feature)

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state=RUN, wait counter=0, mc_timeout=0, stall_count=0.
- While rst=1, the combinational outputs are forced to pc_ld=0, ifid_ld=0, ifid_flush=0, idex_bubble=0.
- States: RUN, MC_WAIT. All outputs other than mc_timeout and stall_count are combinational from state and inputs (zero-latency).
- lu_hazard = idex_memread & (idex_rt!=0) & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).

RUN, priority highest first:
- 1) lu_hazard: pc_ld=0, ifid_ld=0, idex_bubble=1, ifid_flush=0. Any branch_taken or mc_start is ignored this cycle and re-evaluated after the stall. Next state RUN.
- 2) branch_taken: pc_ld=1, ifid_ld=1, ifid_flush=1, idex_bubble=0. Next state RUN.
- 3) mc_start: pc_ld=0, ifid_ld=0, idex_bubble=0. The multi-cycle instruction issues into ID/EX this cycle. Next state MC_WAIT, counter cleared to 0.
- 4) otherwise: pc_ld=1, ifid_ld=1, ifid_flush=0, idex_bubble=0.
- branch_taken and mc_start asserted together: branch wins and mc_start is ignored. A decoder never asserts both.

MC_WAIT:
- mc_done=0: pc_ld=0, ifid_ld=0, idex_bubble=1, ifid_flush=0. Counter increments.
- mc_done=1: outputs as in RUN case 4 (release in the same cycle); next state RUN. Hazard inputs are ignored in this cycle.
- Counter == MC_MAX_CYCLES-1 with mc_done=0: mc_timeout<=1 (sticky until rst), next state RUN. Outputs in that cycle are still the stall values.
- mc_done while in RUN: ignored.
- rst in MC_WAIT: returns to RUN next edge; the counter and flags are cleared.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: stall_count increments every non-reset cycle in which ifid_ld=0, saturating at all-ones. The count includes load-use and MC_WAIT stalls; flush cycles are not counted.
- Undefined: stall_count is tied to 0 and no counter register is synthesised.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8. Expect exactly one cycle of pc_ld=0, ifid_ld=0, idex_bubble=1; the cycle after (idex_memread=0) shows pc_ld=1, ifid_ld=1.
- Register 0 and unused rt: idex_rt=0=ifid_rs gives no stall. idex_rt=9=ifid_rt with ifid_uses_rt=0 gives no stall.
- Branch and load-use together: branch_taken=1 with a load-use hazard. Cycle 1 is a stall with ifid_flush=0. Cycle 2 (hazard gone, branch_taken=1) gives ifid_flush=1, pc_ld=1.
- Multi-cycle: mc_start pulse, then mc_done after 10 cycles. Expect 10 stall cycles with idex_bubble=1, release on the mc_done cycle, and mc_timeout=0. With HAZARD_STALL_CNT_EN, stall_count=11 (issue cycle plus 10 wait cycles).
- Timeout: MC_MAX_CYCLES=4, mc_start, no mc_done. After 4 MC_WAIT cycles, mc_timeout=1 and the state is RUN; mc_timeout stays 1 until rst.
- Reset mid-wait: rst=1 during MC_WAIT. The next cycle shows RUN behaviour, with mc_timeout=0 and stall_count=0.
